// File: rtl/fetch_exec_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_exec_sequencer_if
// Brief    : Instruction-memory fetch bus (req/addr out, ack back).
// Revision : 1.0
// ============================================================================
interface fetch_exec_sequencer_if #(
    parameter int AW = 32
) ();
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;

    modport master (output imem_req, output imem_addr, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface
`default_nettype wire

// File: rtl/fetch_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_exec_sequencer
// Brief    : Multi-cycle FETCH/EXEC/WB controller owning the PC; optional
//            retired-instruction counter under macro SEQ_RETIRE_CNT_EN.
// Revision : 1.0
// ============================================================================
module fetch_exec_sequencer #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] PC_RESET = '0,
    parameter int            PC_STEP  = 4,
    parameter int            TIMEOUT  = 15
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              run,
    fetch_exec_sequencer_if.master imem,
    output logic [AW-1:0]          pc_out,
    output logic                   ir_load,
    output logic                   reg_load,
    input  wire logic              stall,
    input  wire logic              branch_taken,
    input  wire logic [AW-1:0]     branch_target,
    output logic                   fault,
    output logic [2:0]             state_out
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]            retired_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [AW-1:0] c_pc_step   = AW'(PC_STEP);
    localparam logic [7:0]    c_tcnt_last = 8'(TIMEOUT - 1);

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_next_pc;
    logic [7:0]    r_tcnt;
    logic          r_imem_req;
    logic          r_reg_load;
    logic          r_fault;
    logic          w_misaligned;

    assign w_misaligned = branch_taken && (branch_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= PC_RESET;
            r_next_pc  <= PC_RESET;
            r_tcnt     <= 8'd0;
            r_imem_req <= 1'b0;
            r_reg_load <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_reg_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                        r_tcnt     <= 8'd0;
                    end
                end
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        r_state    <= ST_EXEC;
                        r_imem_req <= 1'b0;
                    end else if (r_tcnt == c_tcnt_last) begin
                        r_state    <= ST_FAULT;
                        r_imem_req <= 1'b0;
                        r_fault    <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_EXEC: begin
                    // stall wins over any branch decision presented this cycle
                    if (!stall) begin
                        if (w_misaligned) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_next_pc  <= branch_taken ? branch_target : (r_pc + c_pc_step);
                            r_state    <= ST_WB;
                            r_reg_load <= 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    r_pc <= r_next_pc;
                    if (run) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                        r_tcnt     <= 8'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    r_imem_req <= 1'b0;
                end
                default: begin
                    r_state    <= ST_FAULT;
                    r_imem_req <= 1'b0;
                    r_fault    <= 1'b1;
                end
            endcase
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0] r_retired_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired_cnt <= 32'd0;
        end else if (r_state == ST_WB) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

    // IR load is Mealy so the instruction is captured in the same cycle as ack.
    assign ir_load        = (r_state == ST_FETCH) && imem.imem_ack;
    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    assign pc_out         = r_pc;
    assign reg_load       = r_reg_load;
    assign fault          = r_fault;
    assign state_out      = r_state;

endmodule
`default_nettype wire
